// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one synchronous 32-bit memory between two requesters: port 0 (the
// tarhi CPU) and port 1 (loader / DMA / debug master). Accesses are serialised
// through a three-state FSM (IDLE -> ISSUE -> DONE). Each access takes three
// cycles. Read data is returned only to the port that owned the access.
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins a tie.
//                          undefined : round-robin, strict alternation on ties.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_req/write/addr/wdata    port 0 request, direction, word address, data
//   m0_rdata, m0_ack           port 0 read data (held) and completion pulse
//   m1_*                       port 1, same set of signals as port 0
//   mem_enable/write/addr/dout memory strobe, write enable, address, wdata
//   mem_din                    memory read data, valid the cycle after strobe
//   arb_owner                  port owning the current or last access
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW = 24,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_write,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_write,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic          mem_enable,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_dout,
   input  logic [DW-1:0] mem_din,
   output logic          arb_owner
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_last_grant;
   logic          r_owner;
   logic          r_cmd_write;
   logic          r_mem_enable;
   logic          r_mem_write;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_dout;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          r_ack0;
   logic          r_ack1;

   logic          w_any_req;
   logic          w_win;

   // Pick the winning port for an access starting in IDLE.
   always_comb begin
      w_any_req = m0_req | m1_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
      // Port 0 wins whenever it is requesting; last_grant plays no part.
      if (m0_req) begin
         w_win = 1'b0;
      end else begin
         w_win = 1'b1;
      end
`else
      // On a tie the port that did not take the last access wins.
      if (m0_req && m1_req) begin
         w_win = ~r_last_grant;
      end else if (m1_req) begin
         w_win = 1'b1;
      end else begin
         w_win = 1'b0;
      end
`endif
   end

   // Access sequencer: command latch, memory strobe, read capture and acks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_cmd_write  <= 1'b0;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= {AW{1'b0}};
         r_mem_dout   <= {DW{1'b0}};
         r_rdata0     <= {DW{1'b0}};
         r_rdata1     <= {DW{1'b0}};
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack0 <= 1'b0;
               r_ack1 <= 1'b0;
               if (w_any_req) begin
                  r_owner      <= w_win;
                  r_cmd_write  <= w_win ? m1_write : m0_write;
                  r_mem_write  <= w_win ? m1_write : m0_write;
                  r_mem_addr   <= w_win ? m1_addr  : m0_addr;
                  r_mem_dout   <= w_win ? m1_wdata : m0_wdata;
                  r_mem_enable <= 1'b1;
                  r_state      <= ST_ISSUE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               // Strobe lasts exactly this cycle; ack is raised for the DONE cycle.
               r_mem_enable <= 1'b0;
               r_mem_write  <= 1'b0;
               if (r_owner) begin
                  r_ack1 <= 1'b1;
               end else begin
                  r_ack0 <= 1'b1;
               end
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_ack0 <= 1'b0;
               r_ack1 <= 1'b0;
               if (!r_cmd_write) begin
                  if (r_owner) begin
                     r_rdata1 <= mem_din;
                  end else begin
                     r_rdata0 <= mem_din;
                  end
               end
               r_last_grant <= r_owner;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_mem_enable <= 1'b0;
               r_mem_write  <= 1'b0;
               r_ack0       <= 1'b0;
               r_ack1       <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   // Read data must be valid in the ack cycle, while mem_din is only just
   // arriving; forward it to the owner during DONE, then serve the register.
   always_comb begin
      if ((r_state == ST_DONE) && !r_cmd_write && !r_owner) begin
         m0_rdata = mem_din;
      end else begin
         m0_rdata = r_rdata0;
      end
      if ((r_state == ST_DONE) && !r_cmd_write && r_owner) begin
         m1_rdata = mem_din;
      end else begin
         m1_rdata = r_rdata1;
      end
   end

   assign m0_ack     = r_ack0;
   assign m1_ack     = r_ack1;
   assign mem_enable = r_mem_enable;
   assign mem_write  = r_mem_write;
   assign mem_addr   = r_mem_addr;
   assign mem_dout   = r_mem_dout;
   assign arb_owner  = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A synchronous memory model sits on the
// mem_* bus. Each access pushes its expected owner and read data onto a
// scoreboard queue; a negedge monitor pops one entry per ack and compares.
// Build with MEM_ARB_FIXED_PRIO_EN defined to exercise fixed priority.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 24;
   localparam int DW = 32;

   typedef struct packed {
      logic        port;
      logic        wr;
      logic [31:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          m0_req = 1'b0, m0_write = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic [DW-1:0] m0_rdata;
   logic          m0_ack;
   logic          m1_req = 1'b0, m1_write = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic [DW-1:0] m1_rdata;
   logic          m1_ack;
   logic          mem_enable, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic [DW-1:0] mem_din = '0;
   logic          arb_owner;

   logic [31:0] tb_mem  [0:1023];
   logic [31:0] ref_mem [0:1023];
   exp_t        exp_q[$];
   int          ack_cyc_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din), .arb_owner(arb_owner)
   );

   // Synchronous memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_enable) begin
         if (mem_write) tb_mem[mem_addr[9:0]] <= mem_dout;
         mem_din <= tb_mem[mem_addr[9:0]];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
      else n_pass++;
   endtask

   task automatic preload(input int a, input logic [31:0] d);
      tb_mem[a]  = d;
      ref_mem[a] = d;
   endtask

   task automatic push_exp(input logic port, input logic wr, input logic [23:0] addr, input logic [31:0] d);
      exp_t e;
      e.port = port;
      e.wr   = wr;
      e.data = wr ? 32'd0 : ref_mem[addr[9:0]];
      if (wr) ref_mem[addr[9:0]] = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input logic port, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(port ? m1_ack : m0_ack) && n < budget);
      check_val("ack_seen", 32'(port ? m1_ack : m0_ack), 32'd1);
   endtask

   task automatic drive(input logic port, input logic wr, input logic [23:0] addr, input logic [31:0] d);
      if (port) begin
         m1_write = wr; m1_addr = addr; m1_wdata = d; m1_req = 1'b1;
      end else begin
         m0_write = wr; m0_addr = addr; m0_wdata = d; m0_req = 1'b1;
      end
   endtask

   // Single access from an idle arbiter; ack expected two negedges later.
   task automatic do_access(input logic port, input logic wr, input logic [23:0] addr, input logic [31:0] d);
      int n;
      push_exp(port, wr, addr, d);
      drive(port, wr, addr, d);
      wait_ack(port, 20, n);
      check_val("latency", 32'(n), 32'd2);
      if (port) m1_req = 1'b0; else m0_req = 1'b0;
      @(negedge clk);
   endtask

   // Scoreboard monitor: pops one expectation per ack, tracks held rdata.
   initial begin
      logic [31:0] exp_rd0, exp_rd1;
      logic        prev_en;
      exp_t        e;
      exp_rd0 = 32'd0; exp_rd1 = 32'd0; prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_rd0 = 32'd0; exp_rd1 = 32'd0; prev_en = 1'b0;
         end else begin
            if (mem_enable) check_val("en_pulse", 32'(prev_en), 32'd0);
            prev_en = mem_enable;
            if (m0_ack || m1_ack) begin
               check_val("ack_excl", 32'(m0_ack & m1_ack), 32'd0);
               if (exp_q.size() == 0) begin
                  check_val("unexp_ack", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check_val("ack_port", 32'(m1_ack), 32'(e.port));
                  check_val("owner", 32'(arb_owner), 32'(e.port));
                  if (!e.wr) begin
                     if (e.port) exp_rd1 = e.data; else exp_rd0 = e.data;
                  end
                  ack_cyc_q.push_back(cyc);
               end
            end
            check_val("rdata0", m0_rdata, exp_rd0);
            check_val("rdata1", m1_rdata, exp_rd1);
         end
      end
   end

   initial begin
      int n, acks;
      logic [31:0] d;
      for (int i = 0; i < 1024; i++) preload(i, 32'd0);
      preload(32'h010, 32'hDEADBEEF);
      preload(32'h020, 32'hA0A0_0020);
      preload(32'h030, 32'hB0B0_0030);
      preload(32'h040, 32'hCAFE_F00D);

      // Reset state
      @(negedge clk);
      check_val("rst_en", 32'(mem_enable), 32'd0);
      check_val("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
      check_val("rst_owner", 32'(arb_owner), 32'd0);
      check_val("rst_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Tie from reset: both ports hold req for six accesses
      ack_cyc_q.delete();
      for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         push_exp(1'b0, 1'b0, 24'h20, 32'd0);
`else
         push_exp(i[0], 1'b0, i[0] ? 24'h30 : 24'h20, 32'd0);
`endif
      end
`ifdef MEM_ARB_FIXED_PRIO_EN
      push_exp(1'b1, 1'b0, 24'h30, 32'd0);
`endif
      drive(1'b0, 1'b0, 24'h20, 32'd0);
      drive(1'b1, 1'b0, 24'h30, 32'd0);
      acks = 0; n = 0;
      while (acks < 6 && n < 60) begin
         @(negedge clk);
         n++;
         if (m0_ack || m1_ack) acks++;
      end
      check_val("tie_acks", 32'(acks), 32'd6);
      m0_req = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      wait_ack(1'b1, 10, n);
      check_val("prio_m1_lat", 32'(n), 32'd3);
`endif
      m1_req = 1'b0;
      check_val("tie_q", 32'(ack_cyc_q.size()) >= 32'd6 ? 32'd1 : 32'd0, 32'd1);
      for (int i = 1; i < 6 && i < ack_cyc_q.size(); i++)
         check_val("tie_gap", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);
      repeat (4) @(negedge clk);
      check_val("tie_drain", 32'(exp_q.size()), 32'd0);

      // Test 1: read with bus timing
      push_exp(1'b0, 1'b0, 24'h10, 32'd0);
      drive(1'b0, 1'b0, 24'h10, 32'd0);
      @(negedge clk);
      check_val("t1_en", 32'(mem_enable), 32'd1);
      check_val("t1_addr", 32'(mem_addr), 32'h10);
      check_val("t1_wr", 32'(mem_write), 32'd0);
      check_val("t1_early_ack", 32'(m0_ack), 32'd0);
      @(negedge clk);
      check_val("t1_ack", 32'(m0_ack), 32'd1);
      check_val("t1_m1_ack", 32'(m1_ack), 32'd0);
      check_val("t1_en_off", 32'(mem_enable), 32'd0);
      m0_req = 1'b0;
      @(negedge clk);
      check_val("t1_ack_pulse", 32'(m0_ack), 32'd0);
      check_val("t1_rdata_held", m0_rdata, 32'hDEADBEEF);

      // Test 2: m1 writes, m0 reads back
      do_access(1'b1, 1'b1, 24'h100, 32'h12345678);
      do_access(1'b0, 1'b0, 24'h100, 32'd0);
      check_val("t2_rdata", m0_rdata, 32'h12345678);

      // Cross-port write/read patterns
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         do_access(i[0], 1'b1, 24'h200 + 24'(i), d);
         do_access(~i[0], 1'b0, 24'h200 + 24'(i), 32'd0);
      end

      // Test 5: late request from m1 during m0's ISSUE
      ack_cyc_q.delete();
      push_exp(1'b0, 1'b0, 24'h10, 32'd0);
      push_exp(1'b1, 1'b0, 24'h100, 32'd0);
      drive(1'b0, 1'b0, 24'h10, 32'd0);
      @(negedge clk);
      check_val("t5_issue", 32'(mem_enable), 32'd1);
      drive(1'b1, 1'b0, 24'h100, 32'd0);
      @(negedge clk);
      check_val("t5_m0_ack", 32'(m0_ack), 32'd1);
      m0_req = 1'b0;
      wait_ack(1'b1, 10, n);
      check_val("t5_m1_gap", 32'(n), 32'd3);
      m1_req = 1'b0;
      @(negedge clk);

      // Test 4: reset during ISSUE aborts, held request then completes
      push_exp(1'b0, 1'b0, 24'h40, 32'd0);
      drive(1'b0, 1'b0, 24'h40, 32'h5555_AAAA);
      @(negedge clk);
      check_val("t4_issue", 32'(mem_enable), 32'd1);
      reset = 1'b1;
      #1;
      check_val("t4_en", 32'(mem_enable), 32'd0);
      check_val("t4_wr", 32'(mem_write), 32'd0);
      check_val("t4_addr", 32'(mem_addr), 32'd0);
      check_val("t4_dout", mem_dout, 32'd0);
      check_val("t4_acks", 32'({m0_ack, m1_ack}), 32'd0);
      check_val("t4_rd0", m0_rdata, 32'd0);
      check_val("t4_rd1", m1_rdata, 32'd0);
      check_val("t4_owner", 32'(arb_owner), 32'd0);
      @(negedge clk);
      check_val("t4_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
      reset = 1'b0;
      wait_ack(1'b0, 10, n);
      check_val("t4_resume", 32'(n), 32'd2);
      m0_req = 1'b0;
      repeat (3) @(negedge clk);
      check_val("final_drain", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
